uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte-stream requesters, range 2..8.
REQ-002 Parameter ACK_TIMEOUT, default 4: cycles to wait after a strobe for uart_busy to rise.
REQ-003 Parameter LOCK_TIMEOUT, default 255: idle cycles a locked requester may stall before the grant is forcibly released.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester byte-valid.
REQ-007 req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  byte is the last of a packet; sampled with the byte.
REQ-009 req_ready  output  NUM_REQ  byte accepted when valid&ready; at most one bit high.
REQ-010 uart_we  output  1  one-cycle write strobe to the UART transmitter.
REQ-011 uart_data  output  8  byte presented with uart_we.
REQ-012 uart_busy  input  1  transmitter busy.
REQ-013 grant  output  NUM_REQ  one-hot current owner; all zero when no owner.
REQ-014 ack_err  output  1  one-cycle pulse on an ACK_TIMEOUT expiry.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, ARB, SEND, STROBE, WAIT_ACK and WAIT_DONE.
REQ-016 IDLE: grant=0; if any req_valid is high, go to ARB.
REQ-017 ARB: select the first valid requester in round-robin order, starting at (last_owner+1) mod NUM_REQ; register its grant; go to SEND; if no requester is valid, return to IDLE.
REQ-018 SEND: req_ready[owner]=1 combinationally; on valid&ready, latch the data byte and req_last, go to STROBE.
REQ-019 STROBE: uart_we=1 for exactly one cycle; uart_data equals the latched byte and holds until the next accept.
REQ-020 WAIT_ACK: go to WAIT_DONE when uart_busy=1; after ACK_TIMEOUT cycles without busy, pulse ack_err and go to WAIT_DONE anyway.
REQ-021 WAIT_DONE: wait for uart_busy=0. Then:
 - latched last=0 -> go to SEND with the same owner (packet lock);
 - latched last=1 -> set last_owner=owner and go to IDLE.
REQ-022 Lock timeout: while in SEND with req_valid[owner]=0 for LOCK_TIMEOUT consecutive cycles, release the grant, update last_owner and go to IDLE; the counter clears on every accept.
REQ-023 Accept-to-strobe latency SHALL be exactly 1 cycle; the minimum period between strobes SHALL be 3 cycles plus the busy time.
REQ-024 req_ready SHALL be zero in every state except SEND.
REQ-025 Changes on a non-owner's req_valid SHALL never affect the current packet.
REQ-026 Counters SHALL saturate, never wrap; LOCK_TIMEOUT=0 disables the lock timeout.
REQ-027 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-028 On reset assertion, with no clock required:
 - state=IDLE;
 - grant=0, req_ready=0, uart_we=0, uart_data=8'h00, ack_err=0;
 - last_owner=NUM_REQ-1, so requester 0 has first priority;
 - all counters cleared.
REQ-029 Reset asserted mid-byte SHALL abort the transfer and drop the grant; the byte is not retransmitted.
REQ-030 After reset deassertion, the first possible strobe SHALL be no earlier than the 3rd clock edge.

Structure
REQ-031 The FSM state encoding and the default timeout constants SHALL live in the shared package uart_pkg.
REQ-032 The round-robin priority selector SHALL be the separate sub-module rr_select (inputs: request vector and pointer; output: one-hot grant plus a found flag).
REQ-033 The block SHALL connect directly to uart_tx: we, tx_data and tx_busy map to uart_we, uart_data and uart_busy.

Verification
REQ-034 Single byte: req 0 sends 8'hA5 with last=1 and busy is modelled for 10 cycles -> one uart_we, uart_data=8'hA5, grant returns to 0, no ack_err.
REQ-035 Fairness: all 4 requesters continuously valid with single-byte packets -> strobe order 0,1,2,3,0,... with no starvation.
REQ-036 Packet lock: req 1 sends 3 bytes (last on the 3rd) while req 2 is also valid -> bytes 1a,1b,1c are strobed before any byte from req 2.
REQ-037 Ack timeout: uart_busy tied to 0 -> ack_err pulses ACK_TIMEOUT cycles after each strobe and the FSM keeps progressing.
REQ-038 Lock timeout: req 3 sends one byte with last=0, then drops valid -> grant is released after 255 idle cycles and req 0 is served next.
REQ-039 Reset mid-transfer: assert reset during WAIT_DONE -> all outputs return to reset values immediately and requester 0 is granted first after release.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmit arbiter. It holds
//                the FSM state encoding, the default timeout values and a
//                one-hot to index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_SEND      = 3'd2,
        ST_STROBE    = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    localparam int c_DEF_ACK_TIMEOUT  = 4;
    localparam int c_DEF_LOCK_TIMEOUT = 255;

    // Requester indices are always carried at the width of the largest
    // supported requester count. This keeps the pointer arithmetic
    // independent of NUM_REQ.
    localparam int c_MAX_REQ = 8;
    localparam int c_IDX_W   = 3;

    function automatic logic [c_IDX_W-1:0] oh2idx(input logic [c_MAX_REQ-1:0] oh);
        logic [c_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < c_MAX_REQ; i++) begin
            if (oh[i]) idx = c_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Round-robin priority selector. It picks the first set bit of
//                i_req, starting at position i_ptr and wrapping back to 0.
//  Ports       : i_req   - request vector
//                i_ptr   - highest-priority position (0..NUM_REQ-1)
//                o_gnt   - one-hot selection, all zero when nothing requests
//                o_found - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_select
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [c_IDX_W-1:0] i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_found
);

    localparam logic [NUM_REQ-1:0] c_ONE = NUM_REQ'(1);

    logic [NUM_REQ-1:0] w_at_or_above;
    logic [NUM_REQ-1:0] w_upper;
    logic [NUM_REQ-1:0] w_pick_from;

    // Requests at or above the pointer take priority. When there are none,
    // the search wraps and the lowest request overall wins. x & -x isolates
    // the lowest set bit.
    assign w_at_or_above = ~((c_ONE << i_ptr) - c_ONE);
    assign w_upper       = i_req & w_at_or_above;
    assign w_pick_from   = (|w_upper) ? w_upper : i_req;
    assign o_gnt         = w_pick_from & (~w_pick_from + c_ONE);
    assign o_found       = |i_req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Packet-locking round-robin arbiter. It feeds byte streams
//                from NUM_REQ requesters into a single UART transmitter.
//  Ports       : clk, reset            - clock, async active-high reset
//                req_valid/data/last   - per-requester byte stream
//                req_ready             - accept, only the owner, only in SEND
//                uart_we/uart_data     - write strobe and byte to uart_tx
//                uart_busy             - transmitter busy
//                grant                 - one-hot current owner
//                ack_err               - pulse when busy never rose after a
//                                        strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ACK_TIMEOUT  = c_DEF_ACK_TIMEOUT,
    parameter int LOCK_TIMEOUT = c_DEF_LOCK_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_we,
    output logic [7:0]           uart_data,
    input  logic                 uart_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 ack_err
);

    localparam int                  c_ACK_W    = $clog2(ACK_TIMEOUT + 1) + 1;
    localparam int                  c_LOCK_W   = $clog2(LOCK_TIMEOUT + 1) + 1;
    localparam logic [c_ACK_W-1:0]  c_ACK_LIM  = c_ACK_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LIM = c_LOCK_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
    localparam logic                c_LOCK_EN  = (LOCK_TIMEOUT > 0);

    state_t                r_state;
    state_t                w_next;
    logic [NUM_REQ-1:0]    r_grant;
    logic [c_IDX_W-1:0]    r_owner;
    logic [c_IDX_W-1:0]    r_last_owner;
    logic [7:0]            r_data;
    logic                  r_last;
    logic [c_ACK_W-1:0]    r_ack_cnt;
    logic [c_LOCK_W-1:0]   r_lock_cnt;

    logic [c_IDX_W-1:0]    w_ptr;
    logic [NUM_REQ-1:0]    w_rr_gnt;
    logic                  w_rr_found;
    logic [c_MAX_REQ-1:0]  w_gnt8;
    logic                  w_own_valid;
    logic                  w_own_last;
    logic [7:0]            w_own_data;
    logic                  w_ack_exp;
    logic                  w_lock_exp;
    logic                  w_accept;
    logic                  w_release;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_we;
    logic                  w_ack_err;

    // Search starts one past the previous owner. The pointer wraps from
    // NUM_REQ-1 back to 0.
    assign w_ptr = (r_last_owner == c_LAST_IDX) ? '0 : r_last_owner + c_IDX_W'(1);

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .i_req   (req_valid),
        .i_ptr   (w_ptr),
        .o_gnt   (w_rr_gnt),
        .o_found (w_rr_found)
    );

    always_comb begin
        w_gnt8 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt8[i] = w_rr_gnt[i];
        end
    end

    // Only the owner's lanes are visible. Other requesters cannot influence
    // the packet in flight.
    assign w_own_valid = |(req_valid & r_grant);
    assign w_own_last  = |(req_last & r_grant);

    always_comb begin
        w_own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) w_own_data = w_own_data | req_data[8*i +: 8];
        end
    end

    assign w_ack_exp  = (r_ack_cnt >= c_ACK_LIM);
    assign w_lock_exp = c_LOCK_EN && (r_lock_cnt >= c_LOCK_LIM);

    always_comb begin
        w_next    = r_state;
        w_ready   = '0;
        w_we      = 1'b0;
        w_ack_err = 1'b0;
        w_accept  = 1'b0;
        w_release = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) w_next = ST_ARB;
            end
            ST_ARB: begin
                w_next = w_rr_found ? ST_SEND : ST_IDLE;
            end
            ST_SEND: begin
                w_ready = r_grant;
                if (w_own_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_STROBE;
                end else if (w_lock_exp) begin
                    w_release = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_STROBE: begin
                w_we   = 1'b1;
                w_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (uart_busy) begin
                    w_next = ST_WAIT_DONE;
                end else if (w_ack_exp) begin
                    w_ack_err = 1'b1;
                    w_next    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    if (r_last) begin
                        w_release = 1'b1;
                        w_next    = ST_IDLE;
                    end else begin
                        w_next = ST_SEND;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= c_LAST_IDX;
            r_data       <= 8'h00;
            r_last       <= 1'b0;
            r_ack_cnt    <= '0;
            r_lock_cnt   <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == ST_ARB && w_rr_found) begin
                r_grant <= w_rr_gnt;
                r_owner <= oh2idx(w_gnt8);
            end
            if (w_release) begin
                r_grant      <= '0;
                r_last_owner <= r_owner;
            end

            if (w_accept) begin
                r_data <= w_own_data;
                r_last <= w_own_last;
            end

            if (r_state == ST_WAIT_ACK) begin
                if (r_ack_cnt != '1) r_ack_cnt <= r_ack_cnt + c_ACK_W'(1);
            end else begin
                r_ack_cnt <= '0;
            end

            // Counts consecutive SEND cycles in which the owner has no byte.
            // It clears on accept because the FSM then leaves SEND.
            if (r_state == ST_SEND && !w_own_valid) begin
                if (r_lock_cnt != '1) r_lock_cnt <= r_lock_cnt + c_LOCK_W'(1);
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end

    assign req_ready = w_ready;
    assign uart_we   = w_we;
    assign uart_data = r_data;
    assign grant     = r_grant;
    assign ack_err   = w_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. Requester byte
//                queues drive the inputs, a UART busy model answers each
//                strobe, and a scoreboard of expected (owner, byte) pairs is
//                popped on every strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int ACK_TO  = 4;
    localparam int LOCK_TO = 255;

    typedef struct { logic [7:0] d; logic last; } byte_t;
    typedef struct { int who; logic [7:0] d; } exp_t;
    typedef struct { logic [3:0] mask; int per; logic [31:0] order; int n; } vec_t;

    logic           clk       = 1'b0;
    logic           reset     = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic           uart_busy = 1'b0;
    logic [N-1:0]   req_ready;
    logic           uart_we;
    logic [7:0]     uart_data;
    logic [N-1:0]   grant;
    logic           ack_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int strobes = 0;
    int acks = 0;
    int last_strobe_cyc = 0;
    int first_strobe_cyc = -1;
    int busy_len = 10;
    int busy_cnt = 0;
    logic [N-1:0] acc = '0;
    logic         we_seen = 1'b0;
    logic [N-1:0] exp_gnt;
    exp_t         e;

    byte_t rq[N][$];
    exp_t  exp_q[$];

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .ACK_TIMEOUT  (ACK_TO),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .uart_we   (uart_we),
        .uart_data (uart_data),
        .uart_busy (uart_busy),
        .grant     (grant),
        .ack_err   (ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic bit queues_empty();
        bit r = 1'b1;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        acc     = req_valid & req_ready;
        we_seen = uart_we;
        if (!reset) begin
            if (req_ready != '0) check("ready_is_owner", req_ready, grant);
            if (uart_we) begin
                strobes++;
                last_strobe_cyc = cyc;
                if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", uart_data, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    exp_gnt = '0;
                    exp_gnt[e.who] = 1'b1;
                    check("strobe_data", uart_data, e.d);
                    check("strobe_grant", grant, exp_gnt);
                end
            end
            if (ack_err) begin
                acks++;
                if (busy_len == 0) check("ack_err_delay", cyc - last_strobe_cyc, ACK_TO);
            end
        end
    end

    // UART busy model and requester drivers, updated just after each edge.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            busy_cnt  = 0;
            uart_busy = 1'b0;
        end else begin
            if (we_seen) busy_cnt = busy_len;
            if (busy_cnt > 0) begin
                uart_busy = 1'b1;
                busy_cnt--;
            end else begin
                uart_busy = 1'b0;
            end
        end
        we_seen = 1'b0;
        for (int i = 0; i < N; i++) if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][0].d;
                req_last[i]        = rq[i][0].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_strobes(input string name, input int target, input int limit);
        bit ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            #1;
            if (strobes >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && queues_empty() && grant == '0 && req_valid == '0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[5];
        int   seen[N];
        int   s0, a0, who, rel_cyc, s_cyc;

        // mask, bytes per requester, expected owner order (nibbles from MSB), strobes
        tv[0] = '{4'b1111, 2, 32'h0123_0123, 8};
        tv[1] = '{4'b1010, 2, 32'h1313_0000, 4};
        tv[2] = '{4'b0101, 1, 32'h0200_0000, 2};
        tv[3] = '{4'b1000, 1, 32'h3000_0000, 1};
        tv[4] = '{4'b0110, 3, 32'h1212_1200, 6};

        // Reset values before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        check("rst_we", uart_we, 0);
        check("rst_data", uart_data, 0);
        check("rst_ack_err", ack_err, 0);

        // Single byte, valid already present when reset releases.
        busy_len = 10;
        rq[0].push_back(byte_t'{8'hA5, 1'b1});
        exp_q.push_back(exp_t'{0, 8'hA5});
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        rel_cyc = cyc;
        s0 = strobes;
        a0 = acks;
        wait_idle("single_drain", 200);
        check("single_count", strobes - s0, 1);
        check("first_strobe_not_before_edge3", (first_strobe_cyc - rel_cyc) >= 3, 1);
        check("single_grant_idle", grant, 0);
        check("single_no_ack_err", acks - a0, 0);

        // Round-robin fairness table.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int r = 0; r < N; r++) seen[r] = 0;
            for (int r = 0; r < N; r++)
                if (tv[t].mask[r])
                    for (int j = 0; j < tv[t].per; j++)
                        rq[r].push_back(byte_t'{8'(16*r + j), 1'b1});
            for (int k = 0; k < tv[t].n; k++) begin
                who = int'(tv[t].order[31 - 4*k -: 4]);
                exp_q.push_back(exp_t'{who, 8'(16*who + seen[who])});
                seen[who]++;
            end
            s0 = strobes;
            a0 = acks;
            wait_idle("rr_drain", 2000);
            check("rr_count", strobes - s0, tv[t].n);
            check("rr_no_ack_err", acks - a0, 0);
        end

        // Packet lock: req 1 holds the UART for three bytes. Req 0 becomes
        // valid mid-packet and is served after req 2.
        do_reset();
        rq[1].push_back(byte_t'{8'h1A, 1'b0});
        rq[1].push_back(byte_t'{8'h1B, 1'b0});
        rq[1].push_back(byte_t'{8'h1C, 1'b1});
        rq[2].push_back(byte_t'{8'h2A, 1'b1});
        exp_q.push_back(exp_t'{1, 8'h1A});
        exp_q.push_back(exp_t'{1, 8'h1B});
        exp_q.push_back(exp_t'{1, 8'h1C});
        exp_q.push_back(exp_t'{2, 8'h2A});
        exp_q.push_back(exp_t'{0, 8'h0A});
        s0 = strobes;
        wait_strobes("lock_first_strobe", s0 + 1, 200);
        rq[0].push_back(byte_t'{8'h0A, 1'b1});
        wait_idle("lock_drain", 2000);
        check("lock_count", strobes - s0, 5);

        // Ack timeout: busy never rises.
        do_reset();
        busy_len = 0;
        rq[0].push_back(byte_t'{8'h41, 1'b1});
        rq[0].push_back(byte_t'{8'h42, 1'b1});
        rq[1].push_back(byte_t'{8'h51, 1'b1});
        exp_q.push_back(exp_t'{0, 8'h41});
        exp_q.push_back(exp_t'{1, 8'h51});
        exp_q.push_back(exp_t'{0, 8'h42});
        s0 = strobes;
        a0 = acks;
        wait_idle("ackto_drain", 500);
        check("ackto_count", strobes - s0, 3);
        check("ackto_pulses", acks - a0, 3);
        busy_len = 10;

        // Lock timeout: req 3 sends one non-last byte and goes silent.
        do_reset();
        rq[3].push_back(byte_t'{8'h3C, 1'b0});
        exp_q.push_back(exp_t'{3, 8'h3C});
        exp_q.push_back(exp_t'{0, 8'h0C});
        s0 = strobes;
        a0 = acks;
        wait_strobes("lockto_first_strobe", s0 + 1, 200);
        s_cyc = last_strobe_cyc;
        rq[0].push_back(byte_t'{8'h0C, 1'b1});
        repeat (200) @(negedge clk);
        check("lockto_grant_held", grant, 4'b1000);
        wait_idle("lockto_drain", 1000);
        check("lockto_count", strobes - s0, 2);
        // 10 busy + WAIT_ACK/WAIT_DONE/SEND overhead + 255 idle + IDLE/ARB/SEND
        check("lockto_strobe_gap", last_strobe_cyc - s_cyc, 270);
        check("lockto_no_ack_err", acks - a0, 0);

        // Reset during WAIT_DONE.
        do_reset();
        rq[2].push_back(byte_t'{8'h2D, 1'b1});
        exp_q.push_back(exp_t'{2, 8'h2D});
        s0 = strobes;
        wait_strobes("midrst_strobe", s0 + 1, 200);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_pre_grant", grant, 4'b0100);
        check("midrst_pre_data", uart_data, 8'h2D);
        #1 reset = 1'b1;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_ready", req_ready, 0);
        check("midrst_we", uart_we, 0);
        check("midrst_data", uart_data, 0);
        check("midrst_ack_err", ack_err, 0);
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        rq[2].push_back(byte_t'{8'h2E, 1'b1});
        rq[0].push_back(byte_t'{8'h0E, 1'b1});
        exp_q.push_back(exp_t'{0, 8'h0E});
        exp_q.push_back(exp_t'{2, 8'h2E});
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        s0 = strobes;
        wait_idle("midrst_drain", 500);
        check("midrst_count", strobes - s0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
